// File: rtl/rx_frame_decoder.sv
// rx_frame_decoder: deserializes UART-style framed 10-bit codewords (7 data
// bits + 3 parity bits) from the channel line, checks the parity, and holds
// the recovered word with its error flags on a valid/ready output port.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// stIdle    | line idle, waiting for s=0
// stStart   | timing to the start-bit midpoint; false start returns to idle
// stData    | sampling cw[0]..cw[9] once per bit time
// stStop    | timing to the stop-bit midpoint, then loading the output word
// stWaitHigh| stop bit was 0; hold until the line returns high
module rx_frame_decoder #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    input  logic       out_ready,
    output logic [6:0] out_data,
    output logic       out_valid,
    output logic       par_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        stIdle,
        stStart,
        stData,
        stStop,
        stWaitHigh
    } rxState_t;

    rxState_t        state;
    logic            syncMeta;
    logic            syncOut;
    logic [CntW-1:0] timer;
    logic [3:0]      bitIdx;
    logic [9:0]      shiftReg;
    logic            loadNow;
    logic            acceptNow;
    logic            parMismatch;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncMeta <= 1'b1;
            syncOut  <= 1'b1;
        end else begin
            syncMeta <= ser_in;
            syncOut  <= syncMeta;
        end
    end

    // Load fires on the stop-bit sample; parity is checked on the full shift register.
    always_comb begin
        loadNow     = (state == stStop) && (timer == '0);
        acceptNow   = out_valid && out_ready;
        parMismatch = (shiftReg[7] != ^shiftReg[6:0]) ||
                      (shiftReg[8] != ^shiftReg[3:0]) ||
                      (shiftReg[9] != ^shiftReg[6:4]);
    end

    // Receive FSM with bit timer, shift register and registered output port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= stIdle;
            timer     <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                stIdle: begin
                    if (!syncOut) begin
                        state  <= stStart;
                        timer  <= HalfLoad;
                        bitIdx <= '0;
                    end
                end
                stStart: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (syncOut) begin
                        state <= stIdle;
                    end else begin
                        state  <= stData;
                        timer  <= FullLoad;
                        bitIdx <= '0;
                    end
                end
                stData: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        shiftReg[bitIdx] <= syncOut;
                        timer            <= FullLoad;
                        if (bitIdx == 4'd9) begin
                            state <= stStop;
                        end else begin
                            bitIdx <= bitIdx + 4'd1;
                        end
                    end
                end
                stStop: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        // A held-low line parks in stWaitHigh so it cannot re-trigger.
                        state <= syncOut ? stIdle : stWaitHigh;
                    end
                end
                stWaitHigh: begin
                    if (syncOut) begin
                        state <= stIdle;
                    end
                end
                default: begin
                    state <= stIdle;
                end
            endcase

            // A load wins over an accept at the same edge; overrun only when the
            // previous word was still pending and not being taken.
            if (loadNow) begin
                out_data  <= shiftReg[6:0];
                par_err   <= parMismatch;
                frame_err <= ~syncOut;
                out_valid <= 1'b1;
                overrun   <= out_valid && !out_ready;
            end else if (acceptNow) begin
                out_valid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule
